muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting directly downstream of the register file. It latches the two source operand values and the destination index on a start pulse, and computes the result over a fixed number of cycles with a shift-add/restoring algorithm. It then presents the result and destination index for one cycle so the control path can drive the register-file write port (`rd`, `rd_din`, `write_enable`).

## Interface
- Parameters: none. Datapath width is fixed at 32 bits, matching the register file.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request. Sampled only while `busy`=0.
- `op`  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_val`  in  32  operand A (register-file `rs1_dout`).
- `rs2_val`  in  32  operand B (register-file `rs2_dout`).
- `rd_in`  in  5  destination index, carried through.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `result`/`rd_out` are valid in that cycle.
- `result`  out  32  registered result. Holds its value until the next completion.
- `rd_out`  out  5  latched `rd_in` for the completed operation.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, 5-bit iteration counter.
  - FIN: `busy`=1; sign correction and result write.
- Transitions:
  - IDLE→RUN on `start`. Operands, `op` and `rd_in` are latched; counter is cleared to 0.
  - RUN→FIN when the counter reaches 31, i.e. after the 32nd iteration.
  - FIN→IDLE always. This transition registers `result` and `rd_out` and pulses `done`.
- `start` while `busy`=1 is ignored and not queued. Inputs may change freely after acceptance.
- Multiply:
  - Operands are converted to magnitudes per signedness: MULH signs both, MULHSU signs only rs1, MUL/MULHU sign neither.
  - Each iteration produces one bit of the 64-bit product by shift-add.
  - FIN negates the 64-bit product if the operand signs differ.
  - MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
- Divide: restoring division on magnitudes, one quotient bit per iteration. Signed ops use these sign rules in FIN:
  - Quotient sign = XOR of the operand signs.
  - Remainder sign = dividend sign.
- Boundary results (RISC-V mandated):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter 0. Reset mid-operation aborts the operation: no `done` is produced and `result` is cleared.
- `rd_out`=0 completions still pulse `done`. Discarding the x0 write is the register file's responsibility.

## Timing
- Let E0 be the edge that samples `start`=1 in IDLE.
- `busy` rises after E0. Iterations occur at E1..E32; E32 enters FIN.
- At E33, `result`/`rd_out` update, `done`=1 for the cycle after E33, and `busy` falls at the same edge.
- Latency is 33 cycles from E0 to `done`, fixed for all ops and operands (without the macro below).
- Back-to-back operation: `start` asserted during the `done` cycle is accepted at E34, so the issue rate is one operation per 34 cycles.
- `result` holds its value after `done` falls, until the next FIN.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: divide-by-zero and signed-overflow cases for DIV/DIVU/REM/REMU are detected at acceptance.
  - These cases go IDLE→FIN directly, so `done` is high in the cycle after E1 (1-cycle latency).
  - All other operations are unchanged (33 cycles).
- `MULDIV_EARLY_OUT_EN` undefined: all cases take 33 cycles. Special-case values are produced in FIN.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `result`=0xFFFFFFEB. `done` is seen exactly 33 cycles after the start edge; `busy` is high throughout; `rd_out`=`rd_in`=5.
- MULH/MULHSU/MULHU with 0x80000000 × 0xFFFFFFFF → 0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0.
  - Latency is 33 cycles without `MULDIV_EARLY_OUT_EN` and 1 cycle with it.
- Issue a second `start` at cycle 10 of an operation → it is ignored. `start` in the `done` cycle → accepted, with the second `done` arriving 34 cycles after the first.
- Assert `reset` at cycle 15 of a DIV → next cycle `busy`=0, `result`=0, and no `done` appears within 40 cycles.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiply uses 32 shift-add iterations on operand magnitudes; divide uses
// 32 restoring iterations. Sign correction and RISC-V special cases are
// applied in the FIN state, which also registers result/rd_out and pulses done.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed-overflow
// divides skip the iteration phase and finish one cycle after acceptance.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  rd_out
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] hi_q, hi_d;          // product high half / partial remainder
  logic [31:0] lo_q, lo_d;          // multiplier+product low half / dividend+quotient
  logic [31:0] b_q, b_d;            // multiplicand or divisor magnitude
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic        spec_q, spec_d;      // divide special case detected at acceptance
  logic [31:0] spec_val_q, spec_val_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  rd_out_q, rd_out_d;

  // Operand conditioning at acceptance
  logic        signed_a_s, signed_b_s, neg_a_s, neg_b_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic        div_zero_s, div_ovf_s, spec_s;
  logic [31:0] spec_val_s;

  assign signed_a_s = (op == OP_MULH) | (op == OP_MULHSU) | (op == OP_DIV) | (op == OP_REM);
  assign signed_b_s = (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
  assign neg_a_s    = signed_a_s & rs1_val[31];
  assign neg_b_s    = signed_b_s & rs2_val[31];
  assign mag_a_s    = neg_a_s ? (32'd0 - rs1_val) : rs1_val;
  assign mag_b_s    = neg_b_s ? (32'd0 - rs2_val) : rs2_val;

  assign div_zero_s = op[2] & (rs2_val == 32'd0);
  assign div_ovf_s  = ((op == OP_DIV) | (op == OP_REM)) &
                      (rs1_val == 32'h8000_0000) & (rs2_val == 32'hFFFF_FFFF);
  assign spec_s     = div_zero_s | div_ovf_s;
  // op[1] distinguishes REM/REMU from DIV/DIVU
  assign spec_val_s = div_zero_s ? (op[1] ? rs1_val : 32'hFFFF_FFFF)
                                 : (op[1] ? 32'd0 : 32'h8000_0000);

  // One shift-add multiply step: add multiplicand if LSB set, shift right
  logic [32:0] mul_sum_s;
  logic [31:0] mul_hi_s, mul_lo_s;
  assign mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_hi_s  = mul_sum_s[32:1];
  assign mul_lo_s  = {mul_sum_s[0], lo_q[31:1]};

  // One restoring divide step: shift in next dividend bit, subtract if it fits
  logic [32:0] div_trial_s;
  logic        div_ge_s;
  logic [31:0] div_diff_s, div_hi_s, div_lo_s;
  assign div_trial_s = {hi_q, lo_q[31]};
  assign div_ge_s    = (div_trial_s >= {1'b0, b_q});
  assign div_diff_s  = div_trial_s[31:0] - b_q;
  assign div_hi_s    = div_ge_s ? div_diff_s : div_trial_s[31:0];
  assign div_lo_s    = {lo_q[30:0], div_ge_s};

  // Final sign correction and result selection
  logic [63:0] prod_s, prod_fix_s;
  logic [31:0] mul_res_s, quot_s, rem_s, div_res_s, fin_res_s;
  assign prod_s     = {hi_q, lo_q};
  assign prod_fix_s = (sign_a_q ^ sign_b_q) ? (64'd0 - prod_s) : prod_s;
  assign mul_res_s  = (op_q == OP_MUL) ? prod_fix_s[31:0] : prod_fix_s[63:32];
  assign quot_s     = (sign_a_q ^ sign_b_q) ? (32'd0 - lo_q) : lo_q;
  assign rem_s      = sign_a_q ? (32'd0 - hi_q) : hi_q;
  assign div_res_s  = op_q[1] ? rem_s : quot_s;
  assign fin_res_s  = spec_q ? spec_val_q : (op_q[2] ? div_res_s : mul_res_s);

  // Next-state and datapath update for the IDLE/RUN/FIN sequence
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rd_d       = rd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    b_d        = b_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;
    rd_out_d   = rd_out_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op;
          rd_d       = rd_in;
          cnt_d      = 5'd0;
          sign_a_d   = neg_a_s;
          sign_b_d   = neg_b_s;
          spec_d     = spec_s;
          spec_val_d = spec_val_s;
          hi_d       = 32'd0;
          if (op[2]) begin
            lo_d = mag_a_s;
            b_d  = mag_b_s;
          end else begin
            lo_d = mag_b_s;
            b_d  = mag_a_s;
          end
`ifdef MULDIV_EARLY_OUT_EN
          state_d = spec_s ? S_FIN : S_RUN;
`else
          state_d = S_RUN;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (op_q[2]) begin
          hi_d = div_hi_s;
          lo_d = div_lo_s;
        end else begin
          hi_d = mul_hi_s;
          lo_d = mul_lo_s;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIN: begin
        result_d = fin_res_s;
        rd_out_d = rd_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      op_q       <= 3'd0;
      rd_q       <= 5'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      b_q        <= 32'd0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 32'd0;
      rd_out_q   <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      b_q        <= b_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      rd_out_q   <= rd_out_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, special cases,
// randomized operations against an arithmetic reference model, start
// filtering, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  muldiv_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: RV32M semantics from plain 64-bit/32-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    bit special;
    int lat_special;
    special = o[2] && ((b == 32'd0) ||
              ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MULDIV_EARLY_OUT_EN
    lat_special = 1;
`else
    lat_special = 33;
`endif
    return special ? lat_special : 33;
  endfunction

  // Issue one operation and wait (bounded) for its done pulse.
  // Returns in the done cycle; lat=0 means done never arrived.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                       output int lat, output int busy_bad);
    op = o; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_in = 5'($urandom_range(0, 31));
    lat = 0;
    busy_bad = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_bad++;
    end
    if (done && busy) busy_bad++;
    res = result;
    rdo = rd_out;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'd0; rs1_val = 32'd0; rs2_val = 32'd0; rd_in = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (rd_out !== 5'd0) begin failures++; $display("FAIL reset_rd_out: got %0d want 0", rd_out); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Table-driven directed vectors (test plan values)
  task automatic test_directed();
    logic [2:0]  ops [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd4, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [12] = '{32'h7, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp [12] = '{32'hFFFF_FFEB, 32'h0, 32'h8000_0000, 32'h7FFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res;
    logic [4:0]  rdo;
    logic [4:0]  rd;
    int lat, bb;
    for (int i = 0; i < 12; i++) begin
      rd = (i == 0) ? 5'd5 : 5'(i + 3);
      do_op(ops[i], as[i], bs[i], rd, res, rdo, lat, bb);
      checks++; if (res !== exp[i]) begin failures++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, res, exp[i]); end
      checks++; if (rdo !== rd) begin failures++;
        $display("FAIL directed_rd[%0d]: got %0d want %0d", i, rdo, rd); end
      checks++; if (lat != exp_lat(ops[i], as[i], bs[i])) begin failures++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, exp_lat(ops[i], as[i], bs[i])); end
      checks++; if (bb != 0) begin failures++;
        $display("FAIL directed_busy[%0d]: %0d bad busy cycles, want 0", i, bb); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b, res;
    logic [4:0]  rd, rdo;
    int lat, bb, sel;
    for (int i = 0; i < 60; i++) begin
      o   = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      rd  = 5'($urandom_range(0, 31));
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = 32'($urandom_range(0, 300)); b = 32'd0 - 32'($urandom_range(1, 20)); end
      else if (sel == 3) begin a = 32'd0 - 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
      do_op(o, a, b, rd, res, rdo, lat, bb);
      checks++; if (res !== ref_model(o, a, b)) begin failures++;
        $display("FAIL random_result op=%0d a=%h b=%h: got %h want %h", o, a, b, res, ref_model(o, a, b)); end
      checks++; if (rdo !== rd) begin failures++;
        $display("FAIL random_rd: got %0d want %0d", rdo, rd); end
      checks++; if (lat != exp_lat(o, a, b) || bb != 0) begin failures++;
        $display("FAIL random_timing op=%0d: latency %0d (want %0d), bad busy %0d", o, lat, exp_lat(o, a, b), bb); end
    end
  endtask

  task automatic test_ignore_start();
    int lat, extra;
    op = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd3; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    op = 3'd0; rs1_val = 32'd2; rs2_val = 32'd3; rd_in = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 11; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    checks++; if (lat != 33) begin failures++; $display("FAIL ignore_latency: got %0d want 33", lat); end
    checks++; if (result !== 32'd333) begin failures++; $display("FAIL ignore_result: got %h want %h", result, 32'd333); end
    checks++; if (rd_out !== 5'd9) begin failures++; $display("FAIL ignore_rd: got %0d want 9", rd_out); end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL ignore_queued: got %0d extra done want 0", extra); end
    checks++; if (result !== 32'd333) begin failures++; $display("FAIL ignore_hold: got %h want %h", result, 32'd333); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic [4:0]  rdo;
    int lat, bb, t1, t2;
    do_op(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7, res, rdo, lat, bb);
    t1 = cyc;
    checks++; if (res !== ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678)) begin failures++;
      $display("FAIL b2b_first: got %h want %h", res, ref_model(3'd3, 32'hDEAD_BEEF, 32'h1234_5678)); end
    do_op(3'd4, 32'hFFFF_FC18, 32'd7, 5'd8, res, rdo, lat, bb);
    t2 = cyc;
    checks++; if (res !== 32'hFFFF_FF72) begin failures++; $display("FAIL b2b_second: got %h want %h", res, 32'hFFFF_FF72); end
    checks++; if (t2 - t1 != 34) begin failures++; $display("FAIL b2b_spacing: got %0d want 34", t2 - t1); end
  endtask

  task automatic test_reset_mid();
    int seen;
    op = 3'd4; rs1_val = 32'd12345; rs2_val = 32'd11; rd_in = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (result !== 32'd0) begin failures++; $display("FAIL midreset_result: got %h want 0", result); end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midreset_done: got %0d done pulses want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
